// File: rtl/sr_ff_bank.sv
// rtl/sr_ff_bank.sv - multi-mode flip-flop bank (SR/JK/D/T) with illegal-input monitor
//
// Purpose:
//   WIDTH independent flip-flop channels sharing one clock. Each channel's
//   next state depends on the mode selected on that edge: SR, JK, D or T.
//   A parallel load takes priority over the mode logic. A monitor flags
//   SR-mode cycles in which any channel sees S=R=1. It keeps a per-cycle
//   flag, a saturating event counter and a sticky error bit.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   en           update enable; 0 holds every channel
//   mode         00 SR, 01 JK, 10 D, 11 T
//   a            S / J / D / T per channel
//   b            R / K per channel (ignored in D and T modes)
//   load         parallel load, overrides en and mode
//   load_val     value written into q on load
//   clr_err      clears illegal_cnt and err_sticky
//   q            registered state
//   qbar         ~q
//   illegal      high for the cycle after an S=R=1 update
//   illegal_cnt  saturating count of illegal cycles
//   err_sticky   set by any illegal cycle, held until clr_err

module sr_ff_bank #(
    parameter int   WIDTH     = 4,
    parameter int   CNT_W     = 8,
    parameter int   SR_POLICY = 0,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             err_sticky
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] set_m;
    logic [WIDTH-1:0] rst_m;
    logic [WIDTH-1:0] both_m;
    logic [WIDTH-1:0] hold_m;
    logic [WIDTH-1:0] sr_both;
    logic [WIDTH-1:0] q_mode;
    logic [WIDTH-1:0] q_next;
    logic             illegal_ev;

    // Per-channel input classification shared by SR and JK.
    assign set_m  = a & ~b;
    assign rst_m  = ~a & b;
    assign both_m = a & b;
    assign hold_m = q & ~(a | b);

    // Resolution of S=R=1 in SR mode, fixed at elaboration time.
    always_comb begin
        sr_both = '0;
        if (SR_POLICY == 1) begin
            sr_both = both_m;
        end else if (SR_POLICY == 2) begin
            sr_both = '0;
        end else begin
            sr_both = both_m & q;
        end
    end

    always_comb begin
        q_mode = q;
        case (mode)
            MODE_SR: q_mode = set_m | hold_m | sr_both;
            MODE_JK: q_mode = set_m | hold_m | (both_m & ~q);
            MODE_D:  q_mode = a;
            MODE_T:  q_mode = q ^ a;
            default: q_mode = q;
        endcase
    end

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            q_next = q_mode;
        end
    end

    // One event per cycle no matter how many channels see S=R=1.
    assign illegal_ev = en && !load && (mode == MODE_SR) && (|both_m);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= {WIDTH{RST_VAL}};
        end else begin
            q <= q_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal     <= 1'b0;
            illegal_cnt <= '0;
            err_sticky  <= 1'b0;
        end else begin
            illegal <= illegal_ev;
            // A clear on the same edge as a new event keeps that event.
            if (clr_err) begin
                illegal_cnt <= illegal_ev ? CNT_ONE : '0;
                err_sticky  <= illegal_ev;
            end else begin
                if (illegal_ev && (illegal_cnt != CNT_MAX)) begin
                    illegal_cnt <= illegal_cnt + CNT_ONE;
                end
                err_sticky <= err_sticky | illegal_ev;
            end
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb/tb_sr_ff_bank.sv - self-checking bench for sr_ff_bank with three parameter sets

module tb_sr_ff_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       load;
    logic [3:0] load_val;
    logic       clr_err;

    logic [3:0] q0, q1, q2, qb0, qb1, qb2;
    logic       ill0, ill1, ill2, st0, st1, st2;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance.
    logic [3:0] mq[3];
    int         mcnt[3];
    bit         mill[3];
    bit         mst[3];
    int         pol[3]  = '{0, 1, 2};
    int         cmax[3] = '{255, 3, 255};

    sr_ff_bank #(.WIDTH(4), .CNT_W(8), .SR_POLICY(0), .RST_VAL(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .load(load), .load_val(load_val), .clr_err(clr_err),
        .q(q0), .qbar(qb0), .illegal(ill0), .illegal_cnt(cnt0), .err_sticky(st0));

    sr_ff_bank #(.WIDTH(4), .CNT_W(2), .SR_POLICY(1), .RST_VAL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .load(load), .load_val(load_val), .clr_err(clr_err),
        .q(q1), .qbar(qb1), .illegal(ill1), .illegal_cnt(cnt1), .err_sticky(st1));

    sr_ff_bank #(.WIDTH(4), .CNT_W(8), .SR_POLICY(2), .RST_VAL(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .load(load), .load_val(load_val), .clr_err(clr_err),
        .q(q2), .qbar(qb2), .illegal(ill2), .illegal_cnt(cnt2), .err_sticky(st2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural next state from the rules, channel by channel.
    task automatic model_edge();
        bit ev;
        int ai, bi, qi;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                mq[d] = 4'h0; mill[d] = 0; mcnt[d] = 0; mst[d] = 0;
            end else begin
                ev = en && !load && mode == 2'b00 && ((a & b) != 4'h0);
                if (load) begin
                    mq[d] = load_val;
                end else if (en) begin
                    for (int i = 0; i < 4; i++) begin
                        ai = a[i]; bi = b[i]; qi = mq[d][i];
                        case (mode)
                            2'b00: begin
                                if (ai == 1 && bi == 0) qi = 1;
                                else if (ai == 0 && bi == 1) qi = 0;
                                else if (ai == 1 && bi == 1) begin
                                    if (pol[d] == 1) qi = 1;
                                    else if (pol[d] == 2) qi = 0;
                                end
                            end
                            2'b01: begin
                                if (ai == 1 && bi == 0) qi = 1;
                                else if (ai == 0 && bi == 1) qi = 0;
                                else if (ai == 1 && bi == 1) qi = 1 - qi;
                            end
                            2'b10: qi = ai;
                            default: if (ai == 1) qi = 1 - qi;
                        endcase
                        mq[d][i] = qi[0];
                    end
                end
                mill[d] = ev;
                if (clr_err) begin
                    mcnt[d] = ev ? 1 : 0;
                    mst[d]  = ev;
                end else begin
                    if (ev && mcnt[d] < cmax[d]) mcnt[d] = mcnt[d] + 1;
                    if (ev) mst[d] = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; load = 0; en = 0; clr_err = 0; a = 0; b = 0; mode = 0; load_val = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 1; a = 4'hF; b = 4'h0; mode = 2'b00; load = 0; clr_err = 0;
        tick();
        tick();
        checks++; if (q0 !== 4'h0) begin errors++; $display("FAIL reset_q got %h exp 0", q0); end
        checks++; if (qb0 !== 4'hF) begin errors++; $display("FAIL reset_qbar got %h exp F", qb0); end
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt0); end
        checks++; if (st0 !== 1'b0 || ill0 !== 1'b0) begin errors++; $display("FAIL reset_flags st=%b ill=%b exp 0 0", st0, ill0); end
        rst_n = 1;
        tick();
        checks++; if (q0 !== 4'hF || q2 !== 4'hF) begin errors++; $display("FAIL reset_release q0=%h q2=%h exp F F", q0, q2); end
    endtask

    task automatic test_sr_policy();
        do_reset();
        load = 1; load_val = 4'h5;
        tick();
        load = 0; mode = 2'b00; a = 4'hF; b = 4'hF; en = 1;
        tick();
        checks++; if (q0 !== 4'h5) begin errors++; $display("FAIL sr_hold got %h exp 5", q0); end
        checks++; if (q1 !== 4'hF) begin errors++; $display("FAIL sr_setdom got %h exp F", q1); end
        checks++; if (q2 !== 4'h0) begin errors++; $display("FAIL sr_rstdom got %h exp 0", q2); end
        checks++; if (ill0 !== 1'b1 || cnt0 !== 8'd1 || st0 !== 1'b1) begin errors++; $display("FAIL sr_monitor ill=%b cnt=%0d st=%b exp 1 1 1", ill0, cnt0, st0); end
        en = 0;
        tick();
        checks++; if (ill0 !== 1'b0 || cnt0 !== 8'd1 || st0 !== 1'b1) begin errors++; $display("FAIL sr_after ill=%b cnt=%0d st=%b exp 0 1 1", ill0, cnt0, st0); end
    endtask

    task automatic test_jk_t();
        do_reset();
        load = 1; load_val = 4'h3;
        tick();
        load = 0; mode = 2'b01; a = 4'hF; b = 4'hF; en = 1;
        tick();
        checks++; if (q0 !== 4'hC) begin errors++; $display("FAIL jk_toggle1 got %h exp C", q0); end
        tick();
        checks++; if (q1 !== 4'h3) begin errors++; $display("FAIL jk_toggle2 got %h exp 3", q1); end
        mode = 2'b11; a = 4'h5;
        tick();
        checks++; if (q2 !== 4'h6) begin errors++; $display("FAIL t_toggle got %h exp 6", q2); end
        checks++; if (ill0 !== 1'b0 || st0 !== 1'b0 || cnt0 !== 8'd0) begin errors++; $display("FAIL jk_no_illegal ill=%b st=%b cnt=%0d exp 0 0 0", ill0, st0, cnt0); end
    endtask

    task automatic test_priority_d();
        do_reset();
        load = 1; load_val = 4'hA; en = 1; mode = 2'b10; a = 4'h5;
        tick();
        checks++; if (q0 !== 4'hA) begin errors++; $display("FAIL load_prio got %h exp A", q0); end
        load = 0;
        tick();
        checks++; if (q0 !== 4'h5) begin errors++; $display("FAIL d_mode got %h exp 5", q0); end
        en = 0; a = 4'h0;
        tick();
        checks++; if (q0 !== 4'h5 || qb0 !== 4'hA) begin errors++; $display("FAIL en_hold q=%h qbar=%h exp 5 A", q0, qb0); end
    endtask

    task automatic test_saturation();
        int exp_cnt[5] = '{1, 2, 3, 3, 3};
        do_reset();
        mode = 2'b00; en = 1; a = 4'h1; b = 4'h1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (cnt1 !== 2'(exp_cnt[k])) begin errors++; $display("FAIL sat_cnt step %0d got %0d exp %0d", k, cnt1, exp_cnt[k]); end
            checks++; if (cnt0 !== 8'(k + 1)) begin errors++; $display("FAIL wide_cnt step %0d got %0d exp %0d", k, cnt0, k + 1); end
        end
        clr_err = 1;
        tick();
        checks++; if (cnt1 !== 2'd1 || st1 !== 1'b1 || ill1 !== 1'b1) begin errors++; $display("FAIL clr_with_event cnt=%0d st=%b ill=%b exp 1 1 1", cnt1, st1, ill1); end
        en = 0;
        tick();
        checks++; if (cnt1 !== 2'd0 || st1 !== 1'b0 || cnt0 !== 8'd0) begin errors++; $display("FAIL clr_alone cnt1=%0d st=%b cnt0=%0d exp 0 0 0", cnt1, st1, cnt0); end
        clr_err = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 2'b00; en = 1; a = 4'hF; b = 4'hF;
        tick();
        tick();
        en = 0; load = 1; load_val = 4'h9;
        tick();
        load = 0;
        checks++; if (q0 !== 4'h9 || cnt0 !== 8'd2 || st0 !== 1'b1) begin errors++; $display("FAIL mid_setup q=%h cnt=%0d st=%b exp 9 2 1", q0, cnt0, st0); end
        rst_n = 0; load = 1; load_val = 4'hF; en = 1;
        tick();
        checks++; if (q0 !== 4'h0 || cnt0 !== 8'd0 || st0 !== 1'b0 || ill0 !== 1'b0) begin errors++; $display("FAIL mid_reset q=%h cnt=%0d st=%b ill=%b exp 0 0 0 0", q0, cnt0, st0, ill0); end
        rst_n = 1; load = 0; en = 0;
    endtask

    task automatic test_random();
        logic [3:0] dq[3];
        logic [3:0] dqb[3];
        int         dcnt[3];
        bit         dill[3];
        bit         dst[3];
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom % 25) != 0;
            en       = ($urandom % 4) != 0;
            mode     = 2'($urandom);
            a        = 4'($urandom);
            b        = 4'($urandom);
            load     = ($urandom % 8) == 0;
            load_val = 4'($urandom);
            clr_err  = ($urandom % 12) == 0;
            tick();
            dq   = '{q0, q1, q2};
            dqb  = '{qb0, qb1, qb2};
            dcnt = '{int'(cnt0), int'(cnt1), int'(cnt2)};
            dill = '{ill0, ill1, ill2};
            dst  = '{st0, st1, st2};
            for (int d = 0; d < 3; d++) begin
                checks++; if (dq[d] !== mq[d] || dqb[d] !== ~mq[d]) begin errors++; $display("FAIL rand_q dut%0d cyc %0d q=%h qbar=%h exp %h", d, n, dq[d], dqb[d], mq[d]); end
                checks++; if (dcnt[d] != mcnt[d] || dill[d] != mill[d] || dst[d] != mst[d]) begin errors++; $display("FAIL rand_mon dut%0d cyc %0d cnt=%0d ill=%0d st=%0d exp %0d %0d %0d", d, n, dcnt[d], dill[d], dst[d], mcnt[d], mill[d], mst[d]); end
            end
        end
    endtask

    initial begin
        rst_n = 0; en = 0; mode = 0; a = 0; b = 0; load = 0; load_val = 0; clr_err = 0;
        #1;
        test_reset();
        test_sr_policy();
        test_jk_t();
        test_priority_d();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
